// File: rtl/ahb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ahb_slave_mem: AHB-Lite word memory slave with programmable wait states,  |
// | byte-lane writes and optional ERROR responses (AHB_SLV_ERR_CHECK_EN).      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ahb_slave_mem #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hready_out,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int         AW      = $clog2(MEM_DEPTH);
  localparam int         WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] WS_LOAD = WS_M1[3:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW+1:0] addr_q;
  logic          write_q;
  logic [2:0]    size_q;
  logic          accept;
  logic          legal;
  logic          commit;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   mem [MEM_DEPTH];
  logic          unused_inputs;

  assign unused_inputs = ^{hburst, htrans[0], haddr};

  // Only the cycles that return hready_out=1 can close a data phase.
  assign accept = hsel && htrans[1] && hready_in &&
                  (state == S_IDLE || state == S_DONE || state == S_ERR2);

`ifdef AHB_SLV_ERR_CHECK_EN
  logic range_err, size_err, align_err;
  assign range_err = (haddr[31:AW+2] != '0);
  assign size_err  = (hsize > 3'd2);
  assign align_err = (hsize == 3'd1 && haddr[0]) ||
                     (hsize == 3'd2 && haddr[1:0] != 2'b00);
  assign legal     = !(range_err || size_err || align_err);
`else
  assign legal = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_DONE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
    if (accept) begin
      if (!legal) begin
        state_nxt = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_nxt = S_WAIT;
        cnt_nxt   = WS_LOAD;
      end else begin
        state_nxt = S_DONE;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        addr_q  <= haddr[AW+1:0];
        write_q <= hwrite;
        size_q  <= hsize;
      end
    end
  end

  assign idx = addr_q[AW+1:2];

  // Sub-size address bits are ignored for wider transfers; oversize acts as word.
  always_comb begin
    case (size_q)
      3'd0:    be = 4'b0001 << addr_q[1:0];
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  assign commit = (state == S_DONE) && write_q && !hreset;

  always_ff @(posedge hclk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  // Combinational read lets a read DONE see a write committed one edge earlier.
  assign hready_out = !(state == S_WAIT || state == S_ERR1);
  assign hresp      = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
  assign hrdata     = (state == S_DONE && !write_q) ? mem[idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ahb_slave_mem: directed vector bench for ahb_slave_mem (WAIT_STATES=2  |
// | and WAIT_STATES=0 instances); expectations follow AHB_SLV_ERR_CHECK_EN.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ahb_slave_mem;

  localparam logic [1:0] IDL = 2'b00;
  localparam logic [1:0] BSY = 2'b01;
  localparam logic [1:0] NSQ = 2'b10;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ER  = 2'b01;

  logic        clk;
  logic        hreset;
  logic        hsel_a, hsel_b;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        rdy_a, rdy_b;
  logic [1:0]  resp_a, resp_b;
  logic [31:0] rdata_a, rdata_b;

  int n_checks = 0;
  int n_fail   = 0;

  ahb_slave_mem #(.MEM_DEPTH(1024), .WAIT_STATES(2)) dut (
    .hclk(clk), .hreset(hreset), .hsel(hsel_a), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready_in(rdy_a), .hready_out(rdy_a), .hresp(resp_a), .hrdata(rdata_a)
  );

  ahb_slave_mem #(.MEM_DEPTH(16), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hreset(hreset), .hsel(hsel_b), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hready_in(rdy_b), .hready_out(rdy_b), .hresp(resp_b), .hrdata(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        erdy;
    logic [1:0]  eresp;
    logic [31:0] erd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic sel, input logic [1:0] tr, input logic wr,
                     input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd,
                     input logic erdy, input logic [1:0] eresp, input logic [31:0] erd);
    vec_t v;
    v.sel = sel; v.trans = tr; v.wr = wr; v.size = sz; v.addr = ad; v.wdata = wd;
    v.erdy = erdy; v.eresp = eresp; v.erd = erd;
    vq.push_back(v);
  endtask

  // Data-phase cycle with hready_out low on the WAIT_STATES=2 instance.
  task automatic addw(input logic [31:0] wd);
    add(1'b0, IDL, 1'b0, SW, 32'h0, wd, 1'b0, OK, 32'h0);
  endtask

  task automatic drive(input logic sa, input logic sb, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] ad, input logic [31:0] wd);
    hsel_a = sa; hsel_b = sb; htrans = tr; hwrite = wr; hsize = sz; haddr = ad; hwdata = wd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic rdy, input logic [1:0] resp,
                     input logic [31:0] rd, input logic erdy, input logic [1:0] eresp,
                     input logic [31:0] erd);
    n_checks++;
    if (rdy !== erdy || resp !== eresp || rd !== erd) begin
      n_fail++;
      $display("FAIL %s: got hready_out=%b hresp=%b hrdata=%h, expected hready_out=%b hresp=%b hrdata=%h",
               name, rdy, resp, rd, erdy, eresp, erd);
    end
  endtask

  initial begin
    hreset = 1'b1;
    hburst = 3'b001;
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h0);

    // Write DEADBEEF to 0x10, pipelined read of 0x10 during the write's DONE.
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, OK, 32'h0);
    add(1'b1, NSQ, 1'b1, SW, 32'h10,   32'h0,        1'b1, OK, 32'h0);
    addw(32'hDEADBEEF); addw(32'hDEADBEEF);
    add(1'b1, NSQ, 1'b0, SW, 32'h10,   32'hDEADBEEF, 1'b1, OK, 32'h0);
    addw(32'h0); addw(32'h0);
    // Read DONE; word 0x11223344 to 0x10, then byte AA to 0x13.
    add(1'b1, NSQ, 1'b1, SW, 32'h10,   32'h0,        1'b1, OK, 32'hDEADBEEF);
    addw(32'h11223344); addw(32'h11223344);
    add(1'b1, NSQ, 1'b1, SB, 32'h13,   32'h11223344, 1'b1, OK, 32'h0);
    addw(32'hAA556677); addw(32'hAA556677);
    add(1'b1, NSQ, 1'b0, SW, 32'h10,   32'hAA556677, 1'b1, OK, 32'h0);
    addw(32'h0); addw(32'h0);
    // Half-word BEEF to 0x12 (upper lanes).
    add(1'b1, NSQ, 1'b1, SH, 32'h12,   32'h0,        1'b1, OK, 32'hAA223344);
    addw(32'hBEEF1234); addw(32'hBEEF1234);
    add(1'b1, NSQ, 1'b0, SW, 32'h10,   32'hBEEF1234, 1'b1, OK, 32'h0);
    addw(32'h0); addw(32'h0);
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, OK, 32'hBEEF3344);
    // IDLE with hsel, NONSEQ without hsel, BUSY: all zero-wait OKAY, no writes.
    add(1'b1, IDL, 1'b1, SW, 32'h10,   32'h0,        1'b1, OK, 32'h0);
    add(1'b0, NSQ, 1'b1, SW, 32'h10,   32'h0,        1'b1, OK, 32'h0);
    add(1'b1, BSY, 1'b1, SW, 32'h10,   32'hFFFFFFFF, 1'b1, OK, 32'h0);
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'hFFFFFFFF, 1'b1, OK, 32'h0);
    add(1'b1, NSQ, 1'b0, SW, 32'h10,   32'h0,        1'b1, OK, 32'h0);
    addw(32'h0); addw(32'h0);
    // Memory unchanged; then CAFEF00D to 0x0 and a read of 0x1000.
    add(1'b1, NSQ, 1'b1, SW, 32'h0,    32'h0,        1'b1, OK, 32'hBEEF3344);
    addw(32'hCAFEF00D); addw(32'hCAFEF00D);
    add(1'b1, NSQ, 1'b0, SW, 32'h1000, 32'hCAFEF00D, 1'b1, OK, 32'h0);
`ifdef AHB_SLV_ERR_CHECK_EN
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b0, ER, 32'h0);
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, ER, 32'h0);
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, OK, 32'h0);
`else
    addw(32'h0); addw(32'h0);
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, OK, 32'hCAFEF00D);
`endif
    add(1'b0, IDL, 1'b0, SW, 32'h0,    32'h0,        1'b1, OK, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    hreset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].sel, 1'b0, vq[i].trans, vq[i].wr, vq[i].size, vq[i].addr, vq[i].wdata);
      chk($sformatf("vec%0d", i), rdy_a, resp_a, rdata_a, vq[i].erdy, vq[i].eresp, vq[i].erd);
      step();
    end

    // Reset asserted in WAIT of a write of 0x1234 to 0x8 must not commit it.
    drive(1'b1, 1'b0, NSQ, 1'b1, SW, 32'h8, 32'h0);
    chk("rst_pre_addr", rdy_a, resp_a, rdata_a, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h0BADF00D);
    chk("rst_pre_wait1", rdy_a, resp_a, rdata_a, 1'b0, OK, 32'h0); step();
    chk("rst_pre_wait2", rdy_a, resp_a, rdata_a, 1'b0, OK, 32'h0); step();
    drive(1'b1, 1'b0, NSQ, 1'b1, SW, 32'h8, 32'h0BADF00D);
    chk("rst_pre_done", rdy_a, resp_a, rdata_a, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h00001234);
    hreset = 1'b1;
    chk("rst_in_wait", rdy_a, resp_a, rdata_a, 1'b0, OK, 32'h0); step();
    hreset = 1'b0;
    chk("rst_after", rdy_a, resp_a, rdata_a, 1'b1, OK, 32'h0); step();
    drive(1'b1, 1'b0, NSQ, 1'b0, SW, 32'h8, 32'h0);
    chk("rst_rd_addr", rdy_a, resp_a, rdata_a, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h0);
    chk("rst_rd_wait", rdy_a, resp_a, rdata_a, 1'b0, OK, 32'h0); step(); step();
    chk("rst_readback", rdy_a, resp_a, rdata_a, 1'b1, OK, 32'h0BADF00D); step();

    // Zero-wait instance: back-to-back write 5 to 0x20 then read 0x20.
    drive(1'b0, 1'b1, NSQ, 1'b1, SW, 32'h20, 32'h0);
    chk("b2b_addr", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b1, NSQ, 1'b0, SW, 32'h20, 32'h5);
    chk("b2b_wr_done", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b1, NSQ, 1'b1, SH, 32'h23, 32'h0);
    chk("b2b_rd_done", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h5); step();
`ifdef AHB_SLV_ERR_CHECK_EN
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'hABCD9999);
    chk("mis_err1", rdy_b, resp_b, rdata_b, 1'b0, ER, 32'h0); step();
    drive(1'b0, 1'b1, NSQ, 1'b0, SW, 32'h20, 32'h0);
    chk("mis_err2", rdy_b, resp_b, rdata_b, 1'b1, ER, 32'h0); step();
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h0);
    chk("mis_readback", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h5); step();
`else
    drive(1'b0, 1'b1, NSQ, 1'b0, SW, 32'h60, 32'hABCD9999);
    chk("mis_wr_done", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h0); step();
    drive(1'b0, 1'b0, IDL, 1'b0, SW, 32'h0, 32'h0);
    chk("wrap_readback", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'hABCD0005); step();
`endif
    chk("b_idle_end", rdy_b, resp_b, rdata_b, 1'b1, OK, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
